// File: rtl/multdiv_sequencer_if.sv
// multdiv_sequencer_if: DX/multdiv/writeback signals between the pipeline (master) and the sequencer (slave).
// MDSEQ_PERF_EN adds the performance counter outputs.
interface multdiv_sequencer_if;
  logic [31:0] dx_insn;
  logic        dx_valid;
  logic        md_data_ready;
  logic        md_exception;
  logic [31:0] md_result;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic        stall;
  logic        busy;
  logic        result_valid;
  logic [4:0]  result_reg;
  logic [31:0] result_data;
  logic        result_exc;
`ifdef MDSEQ_PERF_EN
  logic [31:0] perf_ops;
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_timeouts;
  modport master (
    output dx_insn, dx_valid, md_data_ready, md_exception, md_result,
    input  md_ctrl_mult, md_ctrl_div, stall, busy, result_valid, result_reg, result_data, result_exc,
    input  perf_ops, perf_stall_cycles, perf_timeouts
  );
  modport slave (
    input  dx_insn, dx_valid, md_data_ready, md_exception, md_result,
    output md_ctrl_mult, md_ctrl_div, stall, busy, result_valid, result_reg, result_data, result_exc,
    output perf_ops, perf_stall_cycles, perf_timeouts
  );
`else
  modport master (
    output dx_insn, dx_valid, md_data_ready, md_exception, md_result,
    input  md_ctrl_mult, md_ctrl_div, stall, busy, result_valid, result_reg, result_data, result_exc
  );
  modport slave (
    input  dx_insn, dx_valid, md_data_ready, md_exception, md_result,
    output md_ctrl_mult, md_ctrl_div, stall, busy, result_valid, result_reg, result_data, result_exc
  );
`endif
endinterface

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: launches the multi-cycle multdiv unit, stalls the pipeline until ready/timeout, emits one writeback record.
// Optional MDSEQ_PERF_EN adds perf_ops / perf_stall_cycles / perf_timeouts counters.
module multdiv_sequencer #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W = 6
) (
  input logic clock,
  input logic reset,
  multdiv_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [4:0] rd;
  logic is_div;
  logic is_md;
  logic fail;
  logic unused_insn_bits;
  assign is_md = bus.dx_valid && bus.dx_insn[31:27] == 5'b00000 && bus.dx_insn[6:3] == 4'b0011;
  assign fail = !bus.md_data_ready || bus.md_exception;
  assign bus.stall = (state == IDLE && is_md) || state == LAUNCH || state == WAIT;
  assign unused_insn_bits = ^{bus.dx_insn[21:7], bus.dx_insn[1:0]};
`ifdef MDSEQ_PERF_EN
  logic timed_out;
`endif
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rd <= '0;
      is_div <= 1'b0;
      bus.md_ctrl_mult <= 1'b0;
      bus.md_ctrl_div <= 1'b0;
      bus.busy <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.result_reg <= '0;
      bus.result_data <= '0;
      bus.result_exc <= 1'b0;
`ifdef MDSEQ_PERF_EN
      timed_out <= 1'b0;
`endif
    end else
      case (state)
        IDLE:
          if (is_md) begin
            state <= LAUNCH;
            rd <= bus.dx_insn[26:22];
            is_div <= bus.dx_insn[2];
            bus.md_ctrl_mult <= !bus.dx_insn[2];
            bus.md_ctrl_div <= bus.dx_insn[2];
            bus.busy <= 1'b1;
          end
        LAUNCH: begin
          state <= WAIT;
          cnt <= '0;
          bus.md_ctrl_mult <= 1'b0;
          bus.md_ctrl_div <= 1'b0;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // ready takes priority over a timeout expiring in the same cycle
          if (bus.md_data_ready || cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state <= DONE;
            bus.busy <= 1'b0;
            bus.result_valid <= 1'b1;
            bus.result_reg <= fail ? 5'd30 : rd;
            bus.result_data <= fail ? (is_div ? 32'd5 : 32'd4) : bus.md_result;
            bus.result_exc <= fail;
`ifdef MDSEQ_PERF_EN
            timed_out <= !bus.md_data_ready;
`endif
          end
        end
        DONE: begin
          state <= IDLE;
          bus.result_valid <= 1'b0;
        end
      endcase
`ifdef MDSEQ_PERF_EN
  always_ff @(posedge clock)
    if (reset) begin
      bus.perf_ops <= '0;
      bus.perf_stall_cycles <= '0;
      bus.perf_timeouts <= '0;
    end else begin
      bus.perf_ops <= bus.perf_ops + 32'(state == DONE);
      bus.perf_stall_cycles <= bus.perf_stall_cycles + 32'(bus.stall);
      bus.perf_timeouts <= bus.perf_timeouts + 16'(state == DONE && timed_out);
    end
`endif
endmodule
